// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: reserves phase-0 fetch slots for the next visible
// pixel and drains a small CPU write FIFO in every remaining clk50 cycle.
module vga_fb_arbiter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk50,
  input  logic                          reset,
  input  logic [9:0]                    hcount,
  input  logic [9:0]                    vcount,
  input  logic                          pix_phase,
  input  logic                          cpu_valid,
  output logic                          cpu_ready,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  output logic                          cpu_err,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_we,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [DATA_W-1:0]             pix_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          vblank_irq
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] FB_PIXELS = ADDR_W'(640 * 480);
  localparam logic [PTR_W:0]    LVL_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

  logic [10:0]       nc, nl;
  logic              next_active, fetch, pop, push, keep, fetch_q;
  logic [ADDR_W-1:0] fetch_addr, last_addr;
  logic [DATA_W-1:0] last_wdata;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];

  // 11-bit next-pixel coordinates so out-of-range counters cannot wrap into view
  always_comb begin
    if (hcount == 10'd799) begin
      nc = '0;
      nl = (vcount == 10'd524) ? '0 : {1'b0, vcount} + 11'd1;
    end else begin
      nc = {1'b0, hcount} + 11'd1;
      nl = {1'b0, vcount};
    end
  end

  assign next_active = (nc < 11'd640) && (nl < 11'd480);
  assign fetch_addr  = (ADDR_W'(nl) << 9) + (ADDR_W'(nl) << 7) + ADDR_W'(nc);
  assign fetch       = ~pix_phase & next_active;
  assign pop         = ~fetch & (fifo_level != '0);
  assign cpu_ready   = (fifo_level != LVL_FULL);
  assign push        = cpu_valid & cpu_ready;
  assign keep        = push & (cpu_addr < FB_PIXELS);
  assign vblank_irq  = ~reset & (hcount == 10'd0) & (vcount == 10'd480) & ~pix_phase;

  // Reset gates the combinational RAM port so a write in flight is dropped at once
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = last_addr;
    mem_wdata = last_wdata;
    if (reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (fetch) begin
      mem_addr = fetch_addr;
    end else if (pop) begin
      mem_we    = 1'b1;
      mem_addr  = fifo_addr[rd_ptr];
      mem_wdata = fifo_data[rd_ptr];
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      last_addr  <= '0;
      last_wdata <= '0;
      cpu_err    <= 1'b0;
      pix_data   <= '0;
      fetch_q    <= 1'b0;
    end else begin
      if (fetch || pop) last_addr <= mem_addr;
      if (pop) begin
        last_wdata <= mem_wdata;
        rd_ptr     <= rd_ptr + 1'b1;
      end
      if (keep) wr_ptr <= wr_ptr + 1'b1;
      case ({keep, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      cpu_err <= push & ~keep;
      fetch_q <= fetch;
      // Read data of a phase-0 fetch lands in the following phase-1 cycle
      if (pix_phase) pix_data <= fetch_q ? mem_rdata : '0;
    end
  end

  always_ff @(posedge clk50) begin
    if (keep) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_wdata;
    end
  end

endmodule
